spi_slave_axis: RTL and testbench

// - SPI mode-0 target: the far end of the bus driven by our SPI master, i.e. the flash-side behaviour.
// - Oversamples sck/ss/mosi in the clk domain, deserialises MOSI to an AXIS byte master and serialises an AXIS byte slave onto MISO.
// - Used as a flash stand-in on test builds and as a board-to-board control link. Full duplex, MSB first.

---
 rtl/spi_slave_axis_if.sv | 35 +++
 rtl/spi_slave_axis.sv | 159 +++++++++++++++
 tb/tb_spi_slave_axis.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_axis_if.sv
// -----------------------------------------------------------------------------
// spi_slave_axis_if
// Byte-wide AXI-Stream pair used by spi_slave_axis.
//   s_axis_* : bytes to be shifted out on MISO (consumed by the SPI target)
//   m_axis_* : bytes received on MOSI (produced by the SPI target)
// Modports:
//   slave  : the SPI target side (accepts s_axis, drives m_axis)
//   master : the surrounding logic (drives s_axis, accepts m_axis)
// -----------------------------------------------------------------------------
interface spi_slave_axis_if;
   logic       s_axis_tvalid;
   logic       s_axis_tready;
   logic [7:0] s_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready;
   logic [7:0] m_axis_tdata;

   modport slave (
      input  s_axis_tvalid,
      input  s_axis_tdata,
      output s_axis_tready,
      output m_axis_tvalid,
      output m_axis_tdata,
      input  m_axis_tready
   );

   modport master (
      output s_axis_tvalid,
      output s_axis_tdata,
      input  s_axis_tready,
      input  m_axis_tvalid,
      input  m_axis_tdata,
      output m_axis_tready
   );
endinterface

// File: rtl/spi_slave_axis.sv
// -----------------------------------------------------------------------------
// spi_slave_axis
// SPI mode-0 target (MSB first, full duplex). sck/ss/mosi are oversampled in
// the clk domain; received bytes leave on an AXIS master, bytes to transmit
// arrive on an AXIS slave and are serialised onto MISO.
// Ports:
//   clk, sresetn        system clock, asynchronous active-low reset
//   sck, ss, mosi       SPI inputs from the bus master (asynchronous to clk)
//   miso, miso_oe       SPI data out and its pad output enable
//   axis                s_axis (tx bytes in) / m_axis (rx bytes out)
//   frame_start         1-cycle pulse when a frame begins
//   rx_overflow         1-cycle pulse when a completed rx byte is dropped
// -----------------------------------------------------------------------------
module spi_slave_axis #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
   input  logic                  clk,
   input  logic                  sresetn,
   input  logic                  sck,
   input  logic                  ss,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   spi_slave_axis_if.slave       axis,
   output logic                  frame_start,
   output logic                  rx_overflow
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [SYNC_STAGES-1:0] sck_sync_reg, ss_sync_reg, mosi_sync_reg;
   logic       sck_d_reg, ss_d_reg, armed_reg;
   state_t     state_reg;
   logic [2:0] bit_cnt_reg;
   logic [6:0] rx_shift_reg;   // MSB of a byte is never needed once the 8th bit arrives
   logic [6:0] tx_shift_reg;   // bits still to be sent after the one on miso
   logic [7:0] tx_hold_reg;
   logic       miso_reg, miso_oe_reg;
   logic       m_tvalid_reg;
   logic [7:0] m_tdata_reg;
   logic       frame_start_reg, rx_overflow_reg;

   logic       sck_s, ss_s, mosi_s;
   logic       sck_rise, sck_fall, ss_rise, ss_fall;
   logic       load_first, load_next;
   logic [7:0] tx_pick, rx_next;

   // Input synchronisers: new samples enter at bit 0, the output is the MSB.
   always_ff @(posedge clk or negedge sresetn) begin
      if (!sresetn) begin
         sck_sync_reg  <= '0;
         ss_sync_reg   <= '0;
         mosi_sync_reg <= '0;
         sck_d_reg     <= 1'b0;
         ss_d_reg      <= 1'b0;
      end else begin
         sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
         ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], ss};
         mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
         sck_d_reg     <= sck_sync_reg[SYNC_STAGES-1];
         ss_d_reg      <= ss_sync_reg[SYNC_STAGES-1];
      end
   end

   assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
   assign ss_s     = ss_sync_reg[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d_reg;
   assign sck_fall = ~sck_s & sck_d_reg;
   assign ss_rise  = ss_s & ~ss_d_reg;
   assign ss_fall  = ~ss_s & ss_d_reg;

   // Load points: frame start, and every completed byte (ss rise wins over sck).
   assign load_first = (state_reg == IDLE) && ss_fall && armed_reg;
   assign load_next  = (state_reg == ACTIVE) && !ss_rise && sck_rise && (bit_cnt_reg == 3'd7);
   assign tx_pick    = axis.s_axis_tvalid ? axis.s_axis_tdata : FILL_BYTE;
   assign rx_next    = {rx_shift_reg, mosi_s};

   always_ff @(posedge clk or negedge sresetn) begin
      if (!sresetn) begin
         state_reg       <= IDLE;
         armed_reg       <= 1'b0;
         bit_cnt_reg     <= 3'd0;
         rx_shift_reg    <= '0;
         tx_shift_reg    <= '0;
         tx_hold_reg     <= '0;
         miso_reg        <= 1'b0;
         miso_oe_reg     <= 1'b0;
         m_tvalid_reg    <= 1'b0;
         m_tdata_reg     <= '0;
         frame_start_reg <= 1'b0;
         rx_overflow_reg <= 1'b0;
      end else begin
         frame_start_reg <= 1'b0;
         rx_overflow_reg <= 1'b0;
         // A frame in progress at reset release must not be joined mid-way.
         if (ss_s) begin
            armed_reg <= 1'b1;
         end
         if (m_tvalid_reg && axis.m_axis_tready) begin
            m_tvalid_reg <= 1'b0;
         end
         case (state_reg)
            IDLE: begin
               if (load_first) begin
                  state_reg       <= ACTIVE;
                  frame_start_reg <= 1'b1;
                  bit_cnt_reg     <= 3'd0;
                  tx_shift_reg    <= tx_pick[6:0];
                  miso_reg        <= tx_pick[7];
                  miso_oe_reg     <= 1'b1;
               end
            end
            ACTIVE: begin
               if (ss_rise) begin
                  state_reg   <= IDLE;
                  miso_reg    <= 1'b0;
                  miso_oe_reg <= 1'b0;
                  bit_cnt_reg <= 3'd0;
               end else if (sck_rise) begin
                  rx_shift_reg <= rx_next[6:0];
                  bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) begin
                     tx_hold_reg <= tx_pick;
                     if (!m_tvalid_reg || axis.m_axis_tready) begin
                        m_tdata_reg  <= rx_next;
                        m_tvalid_reg <= 1'b1;
                     end else begin
                        rx_overflow_reg <= 1'b1;
                     end
                  end
               end else if (sck_fall) begin
                  // bit_cnt==0 here means the previous byte just finished.
                  if (bit_cnt_reg == 3'd0) begin
                     tx_shift_reg <= tx_hold_reg[6:0];
                     miso_reg     <= tx_hold_reg[7];
                  end else begin
                     tx_shift_reg <= {tx_shift_reg[5:0], 1'b0};
                     miso_reg     <= tx_shift_reg[6];
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // tready is decoded from registered state only, so it is high in exactly
   // the cycle the byte is captured and never depends on tvalid.
   assign axis.s_axis_tready = load_first | load_next;
   assign axis.m_axis_tvalid = m_tvalid_reg;
   assign axis.m_axis_tdata  = m_tdata_reg;
   assign miso               = miso_reg;
   assign miso_oe            = miso_oe_reg;
   assign frame_start        = frame_start_reg;
   assign rx_overflow        = rx_overflow_reg;

endmodule

// File: tb/tb_spi_slave_axis.sv
module tb_spi_slave_axis;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic sresetn, sck, ss, mosi;
   logic miso, miso_oe, frame_start, rx_overflow;

   spi_slave_axis_if axis_if ();

   spi_slave_axis #(.SYNC_STAGES(2), .FILL_BYTE(8'hFF)) dut (
      .clk         (clk),
      .sresetn     (sresetn),
      .sck         (sck),
      .ss          (ss),
      .mosi        (mosi),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .axis        (axis_if),
      .frame_start (frame_start),
      .rx_overflow (rx_overflow)
   );

   int total = 0;
   int bad   = 0;
   int fs_cnt = 0, ovf_cnt = 0, rx_extra = 0;
   bit tx_pop_pending = 1'b0;
   logic [7:0] tx_q[$];        // bytes offered on s_axis, in order
   logic [7:0] rx_exp_q[$];    // expected m_axis bytes
   logic [7:0] miso_exp_q[$];  // expected bytes read by the SPI master

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tx_refresh();
      axis_if.s_axis_tvalid = (tx_q.size() > 0);
      axis_if.s_axis_tdata  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (frame_start) fs_cnt++;
      if (rx_overflow) ovf_cnt++;
      if (axis_if.m_axis_tvalid && axis_if.m_axis_tready) begin
         if (rx_exp_q.size() == 0) begin
            rx_extra++;
            $display("m_axis unexpected byte %02h", axis_if.m_axis_tdata);
         end else begin
            $display("m_axis byte %02h", axis_if.m_axis_tdata);
            chk("m_axis_tdata", {24'd0, axis_if.m_axis_tdata}, {24'd0, rx_exp_q.pop_front()});
         end
      end
      // s_axis source: retire the byte one edge after its transfer.
      if (tx_pop_pending) begin
         tx_q.delete(0);
         tx_pop_pending = 1'b0;
         tx_refresh();
      end
      if (axis_if.s_axis_tready && axis_if.s_axis_tvalid) tx_pop_pending = 1'b1;
   end

   // Mode-0 master, sck = clk/8. Samples miso just before each rising edge.
   task automatic spi_bits(input logic [7:0] tx, input int n, input logic oe_exp,
                           output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - n; i--) begin
         mosi = tx[i];
         repeat (4) tick();
         chk("miso_oe", {31'd0, miso_oe}, {31'd0, oe_exp});
         rx[i] = miso;
         sck = 1'b1;
         repeat (4) tick();
         sck = 1'b0;
      end
   endtask

   task automatic spi_xfer(input logic [7:0] tx, input bit expect_rx);
      logic [7:0] r;
      if (expect_rx) rx_exp_q.push_back(tx);
      spi_bits(tx, 8, 1'b1, r);
      $display("spi byte mosi=%02h miso=%02h", tx, r);
      if (miso_exp_q.size() == 0) chk("miso_exp_avail", 32'd0, 32'd1);
      else chk("miso_byte", {24'd0, r}, {24'd0, miso_exp_q.pop_front()});
   endtask

   task automatic frame_begin();
      ss = 1'b0;
      repeat (6) tick();
   endtask

   task automatic frame_end();
      repeat (4) tick();
      ss = 1'b1;
      repeat (8) tick();
   endtask

   initial begin
      int fs0, ovf0;
      logic [7:0] r;
      logic [7:0] rnd;
      sresetn = 1'b0; ss = 1'b1; sck = 1'b0; mosi = 1'b0;
      axis_if.m_axis_tready = 1'b1;
      tx_refresh();
      repeat (3) tick();
      // Reset state
      chk("rst_miso", {31'd0, miso}, 32'd0);
      chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
      chk("rst_s_tready", {31'd0, axis_if.s_axis_tready}, 32'd0);
      chk("rst_m_tvalid", {31'd0, axis_if.m_axis_tvalid}, 32'd0);
      chk("rst_m_tdata", {24'd0, axis_if.m_axis_tdata}, 32'd0);
      chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
      chk("rst_rx_overflow", {31'd0, rx_overflow}, 32'd0);
      sresetn = 1'b1;
      repeat (8) tick();

      // 1: single byte A5 out, 3C back
      fs0 = fs_cnt;
      tx_q.push_back(8'h3C); tx_refresh();
      miso_exp_q.push_back(8'h3C);
      frame_begin(); spi_xfer(8'hA5, 1'b1); frame_end();
      chk("t1_frame_start", fs_cnt - fs0, 32'd1);
      chk("t1_rx_left", rx_exp_q.size(), 32'd0);
      chk("t1_tx_left", tx_q.size(), 32'd0);
      chk("t1_miso_oe_off", {31'd0, miso_oe}, 32'd0);

      // 2: three bytes, no tx data -> fill bytes
      for (int i = 0; i < 3; i++) miso_exp_q.push_back(8'hFF);
      frame_begin();
      spi_xfer(8'h12, 1'b1); spi_xfer(8'h34, 1'b1); spi_xfer(8'h56, 1'b1);
      frame_end();
      chk("t2_rx_left", rx_exp_q.size(), 32'd0);

      // 3: downstream stalled -> 11 held, 22 dropped with one overflow
      ovf0 = ovf_cnt;
      axis_if.m_axis_tready = 1'b0;
      miso_exp_q.push_back(8'hFF); miso_exp_q.push_back(8'hFF);
      frame_begin(); spi_xfer(8'h11, 1'b1); spi_xfer(8'h22, 1'b0); frame_end();
      chk("t3_overflow", ovf_cnt - ovf0, 32'd1);
      chk("t3_m_tvalid", {31'd0, axis_if.m_axis_tvalid}, 32'd1);
      chk("t3_m_tdata", {24'd0, axis_if.m_axis_tdata}, 32'h11);
      axis_if.m_axis_tready = 1'b1;
      repeat (4) tick();
      chk("t3_rx_left", rx_exp_q.size(), 32'd0);
      chk("t3_m_tvalid_clr", {31'd0, axis_if.m_axis_tvalid}, 32'd0);

      // 4: frame aborted after 5 bits of F0, then a clean 0F
      frame_begin(); spi_bits(8'hF0, 5, 1'b1, r);
      ss = 1'b1;
      repeat (8) tick();
      chk("t4_miso_oe", {31'd0, miso_oe}, 32'd0);
      chk("t4_miso", {31'd0, miso}, 32'd0);
      chk("t4_m_tvalid", {31'd0, axis_if.m_axis_tvalid}, 32'd0);
      miso_exp_q.push_back(8'hFF);
      frame_begin(); spi_xfer(8'h0F, 1'b1); frame_end();
      chk("t4_rx_left", rx_exp_q.size(), 32'd0);

      // 5: reset released mid-frame -> frame ignored until ss high then low
      sresetn = 1'b0; ss = 1'b0;
      repeat (3) tick();
      sresetn = 1'b1;
      fs0 = fs_cnt;
      repeat (2) tick();
      spi_bits(8'h5A, 8, 1'b0, r);
      repeat (4) tick();
      chk("t5_m_tvalid", {31'd0, axis_if.m_axis_tvalid}, 32'd0);
      chk("t5_no_start", fs_cnt - fs0, 32'd0);
      ss = 1'b1;
      repeat (8) tick();
      miso_exp_q.push_back(8'hFF);
      frame_begin(); spi_xfer(8'h81, 1'b1); frame_end();
      chk("t5_frame_start", fs_cnt - fs0, 32'd1);
      chk("t5_rx_left", rx_exp_q.size(), 32'd0);

      // 6: 16-byte frame, random data both ways
      ovf0 = ovf_cnt;
      for (int i = 0; i < 17; i++) begin
         rnd = 8'($urandom_range(0, 255));
         tx_q.push_back(rnd);
         if (i < 16) miso_exp_q.push_back(rnd);
      end
      tx_refresh();
      frame_begin();
      for (int i = 0; i < 16; i++) spi_xfer(8'($urandom_range(0, 255)), 1'b1);
      frame_end();
      chk("t6_overflow", ovf_cnt - ovf0, 32'd0);
      chk("t6_rx_left", rx_exp_q.size(), 32'd0);
      chk("t6_tx_left", tx_q.size(), 32'd0);

      chk("rx_extra", rx_extra, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
